// File: rtl/slifo_pkg.sv
// rtl/slifo_pkg.sv - shared defaults and FSM state encoding for the LIFO pop controller
//
// Contents:
//   SLIFO_DATA_WIDTH    default width of one LIFO entry
//   SLIFO_POINTER_WIDTH default LIFO pointer width (depth = 2**SLIFO_POINTER_WIDTH)
//   state_t             pop controller states, IDLE=0 POP=1 DRAIN=2 DONE=3
package slifo_pkg;

  localparam int SLIFO_DATA_WIDTH    = 8;
  localparam int SLIFO_POINTER_WIDTH = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    POP   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/slifo_pop_skid.sv
// rtl/slifo_pop_skid.sv - 2-entry FIFO output buffer between the LIFO read port and the consumer
//
// Ports:
//   clk, rst   clock, asynchronous active-high reset
//   push       write push_data this cycle
//   push_data  entry to store
//   pop        consumer took the head entry this cycle (only while count != 0)
//   head       oldest stored entry
//   count      occupancy, 0..2
module slifo_pop_skid
  import slifo_pkg::*;
#(
  parameter int DATA_WIDTH = SLIFO_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic [DATA_WIDTH-1:0] head,
  output logic [1:0]            count
);

  logic [DATA_WIDTH-1:0] mem [2];
  logic                  wr_ptr;
  logic                  rd_ptr;

  assign head = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/slifo_pop_ctrl.sv
// rtl/slifo_pop_ctrl.sv - pops a burst of entries from a LIFO and streams them out top-of-stack first
//
// Ports:
//   clk, rst     clock, asynchronous active-high reset
//   start        one-cycle burst request, honoured only in IDLE
//   burst_len    entries requested, sampled with start
//   abort        (only with SLIFO_POP_ABORT_EN) stop popping, deliver what is buffered
//   lifo_empty   LIFO empty flag
//   lifo_rd      pop strobe to the LIFO
//   lifo_data    LIFO read data, valid the cycle after lifo_rd
//   out_valid    out_data holds a popped entry
//   out_ready    consumer accepts out_data
//   out_data     popped entry
//   busy         controller is not IDLE
//   done         one-cycle pulse at burst completion
//   short_burst  LIFO ran empty (or abort) before burst_len pops; valid with done
//   pop_count    entries popped in the last burst, held until the next start
//
// Optional feature macro: SLIFO_POP_ABORT_EN adds the abort input.
module slifo_pop_ctrl
  import slifo_pkg::*;
#(
  parameter int DATA_WIDTH    = SLIFO_DATA_WIDTH,
  parameter int POINTER_WIDTH = SLIFO_POINTER_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [POINTER_WIDTH:0] burst_len,
`ifdef SLIFO_POP_ABORT_EN
  input  logic                   abort,
`endif
  input  logic                   lifo_empty,
  output logic                   lifo_rd,
  input  logic [DATA_WIDTH-1:0]  lifo_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [DATA_WIDTH-1:0]  out_data,
  output logic                   busy,
  output logic                   done,
  output logic                   short_burst,
  output logic [POINTER_WIDTH:0] pop_count
);

  state_t                 state;
  logic [POINTER_WIDTH:0] remaining;
  logic                   in_flight;
  logic [1:0]             occ;
  logic                   xfer;
  logic [2:0]             committed;
  logic                   abort_req;

`ifdef SLIFO_POP_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  assign out_valid = (occ != 2'd0);
  assign xfer      = out_valid & out_ready;

  // Slots the buffer will hold after this cycle: stored + arriving - leaving.
  // Counting the departing entry lets a pop issue every cycle under full flow.
  assign committed = {1'b0, occ} + {2'b0, in_flight} - {2'b0, xfer};

  // Combinational so lifo_empty and abort gate the strobe in the same cycle.
  assign lifo_rd = (state == POP) && (remaining != '0) && !lifo_empty &&
                   !abort_req && (committed < 3'd2);

  slifo_pop_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst      (rst),
    .push     (in_flight),
    .push_data(lifo_data),
    .pop      (xfer),
    .head     (out_data),
    .count    (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      remaining   <= '0;
      in_flight   <= 1'b0;
      pop_count   <= '0;
      short_burst <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      in_flight <= lifo_rd;
      done      <= 1'b0;
      if (lifo_rd) begin
        remaining <= remaining - 1'b1;
        pop_count <= pop_count + 1'b1;
      end
      case (state)
        IDLE: begin
          if (start) begin
            state       <= POP;
            busy        <= 1'b1;
            remaining   <= burst_len;
            pop_count   <= '0;
            short_burst <= 1'b0;
          end
        end
        POP: begin
          if (abort_req) begin
            state       <= DRAIN;
            short_burst <= 1'b1;
          end else if (remaining == '0) begin
            state <= DRAIN;
          end else if (lifo_empty && !in_flight) begin
            state       <= DRAIN;
            short_burst <= 1'b1;
          end
        end
        DRAIN: begin
          if (occ == 2'd0 && !in_flight) begin
            state <= DONE;
            done  <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slifo_pop_ctrl.sv
// tb/tb_slifo_pop_ctrl.sv - directed self-checking bench for slifo_pop_ctrl with a behavioural LIFO
module tb_slifo_pop_ctrl;

  localparam int DW = 8;
  localparam int PW = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [PW:0]   burst_len = '0;
  logic          abort = 1'b0;
  logic          lifo_empty;
  logic          lifo_rd;
  logic [DW-1:0] lifo_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
  logic          short_burst;
  logic [PW:0]   pop_count;

  int tests = 0;
  int failed = 0;

  logic [DW-1:0] stack [0:15];
  int            sp = 0;
  logic          push_en = 1'b0;
  logic [DW-1:0] push_val = '0;
  int            pops = 0;
  int            underflow = 0;
  logic [DW-1:0] got [$];

  always #5 clk = ~clk;

  slifo_pop_ctrl #(.DATA_WIDTH(DW), .POINTER_WIDTH(PW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .burst_len  (burst_len),
`ifdef SLIFO_POP_ABORT_EN
    .abort      (abort),
`endif
    .lifo_empty (lifo_empty),
    .lifo_rd    (lifo_rd),
    .lifo_data  (lifo_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy),
    .done       (done),
    .short_burst(short_burst),
    .pop_count  (pop_count)
  );

  assign lifo_empty = (sp == 0);

  // Behavioural LIFO with registered read data, plus transfer/pop monitor.
  always @(posedge clk) begin
    if (push_en) begin
      stack[sp] <= push_val;
      sp <= sp + 1;
    end else if (lifo_rd && sp > 0) begin
      lifo_data <= stack[sp-1];
      sp <= sp - 1;
    end
    if (lifo_rd) pops <= pops + 1;
    if (lifo_rd && lifo_empty) underflow <= underflow + 1;
    if (out_valid && out_ready) got.push_back(out_data);
  end

  task automatic push(input logic [DW-1:0] v);
    push_en = 1'b1;
    push_val = v;
    @(negedge clk);
    push_en = 1'b0;
  endtask

  task automatic begin_burst(input int len);
    burst_len = (PW+1)'(len);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output bit seen);
    seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (done) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    @(negedge clk);
    @(negedge clk);
    tests++; if ({lifo_rd, out_valid, busy, done, short_burst} !== 5'b0) begin failed++; $display("FAIL reset_flags: got %b expected 00000", {lifo_rd, out_valid, busy, done, short_burst}); end
    tests++; if (pop_count !== '0) begin failed++; $display("FAIL reset_pop_count: got %0d expected 0", pop_count); end
    tests++; if (out_data !== '0) begin failed++; $display("FAIL reset_out_data: got %0d expected 0", out_data); end
    rst = 1'b0;
    @(negedge clk);
    tests++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic;
    int g0, rd_n, rd_first, rd_last;
    bit seen;
    push(8'd5); push(8'd6); push(8'd7);
    out_ready = 1'b1;
    g0 = got.size();
    rd_n = 0; rd_first = -1; rd_last = -1; seen = 1'b0;
    burst_len = 4'd3;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (lifo_rd) begin
        rd_n++;
        if (rd_first < 0) rd_first = i;
        rd_last = i;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    tests++; if (!seen) begin failed++; $display("FAIL basic_done: got no done expected done within 30 cycles"); end
    tests++; if (rd_n != 3 || rd_last - rd_first != 2) begin failed++; $display("FAIL basic_rd_consecutive: got %0d pops over span %0d expected 3 over 2", rd_n, rd_last - rd_first); end
    tests++; if (pop_count !== 4'd3) begin failed++; $display("FAIL basic_pop_count: got %0d expected 3", pop_count); end
    tests++; if (short_burst !== 1'b0) begin failed++; $display("FAIL basic_short: got %b expected 0", short_burst); end
    tests++; if (got.size() - g0 != 3) begin failed++; $display("FAIL basic_count: got %0d expected 3", got.size() - g0); end
    else begin
      tests++; if (got[g0] !== 8'd7) begin failed++; $display("FAIL basic_data0: got %0d expected 7", got[g0]); end
      tests++; if (got[g0+1] !== 8'd6) begin failed++; $display("FAIL basic_data1: got %0d expected 6", got[g0+1]); end
      tests++; if (got[g0+2] !== 8'd5) begin failed++; $display("FAIL basic_data2: got %0d expected 5", got[g0+2]); end
    end
    @(negedge clk);
  endtask

  task automatic test_short_burst;
    int g0, p0;
    bit seen;
    push(8'd1); push(8'd2);
    out_ready = 1'b1;
    g0 = got.size(); p0 = pops;
    begin_burst(5);
    wait_done(seen);
    tests++; if (!seen) begin failed++; $display("FAIL short_done: got no done expected done"); end
    tests++; if (pop_count !== 4'd2) begin failed++; $display("FAIL short_pop_count: got %0d expected 2", pop_count); end
    tests++; if (short_burst !== 1'b1) begin failed++; $display("FAIL short_flag: got %b expected 1", short_burst); end
    tests++; if (pops - p0 != 2) begin failed++; $display("FAIL short_pops: got %0d expected 2", pops - p0); end
    tests++; if (underflow != 0) begin failed++; $display("FAIL short_underflow: got %0d expected 0", underflow); end
    tests++; if (got.size() - g0 != 2 || got[g0] !== 8'd2 || got[g0+1] !== 8'd1) begin failed++; $display("FAIL short_data: got %0d entries expected 2,1", got.size() - g0); end
    @(negedge clk);
  endtask

  task automatic test_backpressure;
    int g0, p0;
    bit seen, have;
    logic [DW-1:0] held;
    push(8'd10); push(8'd11); push(8'd12); push(8'd13);
    out_ready = 1'b0;
    g0 = got.size(); p0 = pops; have = 1'b0; held = '0;
    begin_burst(4);
    for (int i = 0; i < 6; i++) begin
      tests++; if ((pops - p0) - (got.size() - g0) > 2) begin failed++; $display("FAIL bp_outstanding: got %0d expected <= 2", (pops - p0) - (got.size() - g0)); end
      if (out_valid) begin
        if (!have) begin
          held = out_data;
          have = 1'b1;
        end else begin
          tests++; if (out_data !== held) begin failed++; $display("FAIL bp_stable: got %0d expected %0d", out_data, held); end
        end
      end
      @(negedge clk);
    end
    tests++; if (pops - p0 != 2) begin failed++; $display("FAIL bp_pops_stalled: got %0d expected 2", pops - p0); end
    tests++; if (!have || held !== 8'd13) begin failed++; $display("FAIL bp_head: got %0d expected 13", held); end
    out_ready = 1'b1;
    wait_done(seen);
    tests++; if (!seen) begin failed++; $display("FAIL bp_done: got no done expected done"); end
    tests++; if (pop_count !== 4'd4) begin failed++; $display("FAIL bp_pop_count: got %0d expected 4", pop_count); end
    tests++; if (got.size() - g0 != 4) begin failed++; $display("FAIL bp_count: got %0d expected 4", got.size() - g0); end
    else begin
      for (int k = 0; k < 4; k++) begin
        tests++; if (got[g0+k] !== 8'(13 - k)) begin failed++; $display("FAIL bp_data%0d: got %0d expected %0d", k, got[g0+k], 13 - k); end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_zero_len;
    int p0, dcyc;
    push(8'd20); push(8'd21); push(8'd22);
    out_ready = 1'b1;
    p0 = pops; dcyc = -1;
    burst_len = '0;
    start = 1'b1;
    for (int cyc = 1; cyc <= 10; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (done) begin
        dcyc = cyc;
        break;
      end
    end
    tests++; if (dcyc != 3) begin failed++; $display("FAIL zero_done_latency: got %0d expected 3", dcyc); end
    tests++; if (pops - p0 != 0) begin failed++; $display("FAIL zero_pops: got %0d expected 0", pops - p0); end
    tests++; if (pop_count !== '0) begin failed++; $display("FAIL zero_pop_count: got %0d expected 0", pop_count); end
    tests++; if (short_burst !== 1'b0) begin failed++; $display("FAIL zero_short: got %b expected 0", short_burst); end
    @(negedge clk);
  endtask

  task automatic test_reset_mid;
    int g0;
    bit seen;
    push(8'd23); push(8'd24);
    out_ready = 1'b1;
    burst_len = 4'd5;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    tests++; if ({lifo_rd, out_valid, busy, done, short_burst} !== 5'b0) begin failed++; $display("FAIL midrst_flags: got %b expected 00000", {lifo_rd, out_valid, busy, done, short_burst}); end
    tests++; if (pop_count !== '0 || out_data !== '0) begin failed++; $display("FAIL midrst_values: got pop_count %0d out_data %0d expected 0 0", pop_count, out_data); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    g0 = got.size();
    begin_burst(2);
    wait_done(seen);
    tests++; if (!seen) begin failed++; $display("FAIL midrst_done: got no done expected done"); end
    tests++; if (pop_count !== 4'd2 || short_burst !== 1'b0) begin failed++; $display("FAIL midrst_status: got %0d/%b expected 2/0", pop_count, short_burst); end
    tests++; if (got.size() - g0 != 2 || got[g0] !== 8'd22 || got[g0+1] !== 8'd21) begin failed++; $display("FAIL midrst_data: got %0d entries expected 22,21", got.size() - g0); end
    @(negedge clk);
  endtask

`ifdef SLIFO_POP_ABORT_EN
  task automatic test_abort;
    int g0, p0;
    bit seen;
    for (int k = 0; k < 8; k++) push(8'(40 + k));
    out_ready = 1'b1;
    g0 = got.size(); p0 = pops;
    begin_burst(8);
    for (int i = 0; i < 20 && pops - p0 < 2; i++) @(negedge clk);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    wait_done(seen);
    tests++; if (!seen) begin failed++; $display("FAIL abort_done: got no done expected done"); end
    tests++; if (pop_count !== 4'd2 || short_burst !== 1'b1) begin failed++; $display("FAIL abort_status: got %0d/%b expected 2/1", pop_count, short_burst); end
    tests++; if (got.size() - g0 != 2 || got[g0] !== 8'd47 || got[g0+1] !== 8'd46) begin failed++; $display("FAIL abort_data: got %0d entries expected 47,46", got.size() - g0); end
    @(negedge clk);
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_short_burst();
    test_backpressure();
    test_zero_len();
    test_reset_mid();
`ifdef SLIFO_POP_ABORT_EN
    test_abort();
`endif
    tests++; if (underflow != 0) begin failed++; $display("FAIL final_underflow: got %0d expected 0", underflow); end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/slifo_pop_ctrl.md
SLIFO_POP_CTRL -- requirements
Module: slifo_pop_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, the width of one LIFO entry.
REQ-002 SHALL have parameter POINTER_WIDTH, default 3, giving a LIFO depth of 2^POINTER_WIDTH.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: one-cycle request to begin a pop burst.
REQ-006 SHALL have port burst_len, input, POINTER_WIDTH+1 bits: entries requested, sampled with start.
REQ-007 SHALL have port lifo_empty, input, 1 bit: the LIFO empty flag.
REQ-008 SHALL have port lifo_rd, output, 1 bit: pop strobe to the LIFO.
REQ-009 SHALL have port lifo_data, input, DATA_WIDTH bits: LIFO data_out, valid the cycle after lifo_rd.
REQ-010 SHALL have port out_valid, output, 1 bit: out_data holds a popped entry.
REQ-011 SHALL have port out_ready, input, 1 bit: downstream accepts; transfer when out_valid and out_ready.
REQ-012 SHALL have port out_data, output, DATA_WIDTH bits: popped entry, in top-of-stack-first order.
REQ-013 SHALL have port busy, output, 1 bit: high in any state other than IDLE.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a burst completes.
REQ-015 SHALL have port short_burst, output, 1 bit: valid with done; the LIFO emptied before burst_len pops.
REQ-016 SHALL have port pop_count, output, POINTER_WIDTH+1 bits: entries popped in the last burst, held until the next start.

Function
REQ-017 SHALL implement the states IDLE, POP, DRAIN and DONE.
REQ-018 SHALL go IDLE->POP on start; it SHALL latch burst_len into remaining and clear pop_count and short_burst.
REQ-019 SHALL ignore start in every state other than IDLE.
REQ-020 SHALL assert lifo_rd in POP only when remaining>0, lifo_empty=0 and (buffered entries + in-flight pops) < 2.
REQ-021 SHALL, on each lifo_rd, decrement remaining and increment pop_count, and write lifo_data into the 2-entry output buffer one cycle later.
REQ-022 SHALL present the output buffer as a FIFO: the oldest entry drives out_data, and out_data is stable while out_valid=1 and out_ready=0.
REQ-023 SHALL sustain one pop and one transfer per cycle while out_ready=1 and the LIFO is non-empty.
REQ-024 SHALL go POP->DRAIN when remaining=0, or when lifo_empty=1 with no pop in flight; the second case sets short_burst=1.
REQ-025 SHALL go DRAIN->DONE when the buffer is empty and no pop is in flight.
REQ-026 SHALL go DONE->IDLE unconditionally, with done=1 for exactly that cycle.
REQ-027 SHALL treat burst_len=0 as a burst with no lifo_rd: IDLE->POP->DRAIN->DONE, done after 3 cycles, pop_count=0, short_burst=0.
REQ-028 SHALL never assert lifo_rd while lifo_empty=1, so it never causes a LIFO underflow.

Reset
REQ-029 SHALL on rst, including mid-burst, go to IDLE, empty the buffer, discard any in-flight pop, and drive lifo_rd, out_valid, busy, done and short_burst to 0, and pop_count and out_data to 0.

Configuration
REQ-030 SHALL, with SLIFO_POP_ABORT_EN defined, add a 1-bit input abort; abort in POP stops new pops and goes to DRAIN, the buffered entries are still delivered, and done is given with short_burst=1.
REQ-031 SHALL, without SLIFO_POP_ABORT_EN, have no abort port, and behaviour SHALL be exactly as in REQ-017..REQ-028.

Structure
REQ-032 SHALL take DATA_WIDTH and POINTER_WIDTH defaults and the state encoding (IDLE=0, POP=1, DRAIN=2, DONE=3) from the shared package slifo_pkg.
REQ-033 SHALL place the 2-entry output buffer in the sub-module slifo_pop_skid, which reports its occupancy 0..2.

Verification
REQ-034 SHALL cover: push 5,6,7 then start with burst_len=3 and out_ready=1 -> lifo_rd high for 3 consecutive cycles, out_data 7,6,5, done with pop_count=3 and short_burst=0.
REQ-035 SHALL cover: LIFO holding 2 entries, burst_len=5 -> exactly 2 pops, done with pop_count=2 and short_burst=1, no lifo_rd while empty.
REQ-036 SHALL cover: burst_len=4 with out_ready low for 6 cycles -> at most 2 pops outstanding, out_data held stable, all 4 entries delivered in order once ready returns.
REQ-037 SHALL cover: burst_len=0 -> no lifo_rd, done 3 cycles after start, pop_count=0.
REQ-038 SHALL cover: rst asserted in the third POP cycle -> all outputs 0 asynchronously, and a later start with burst_len=2 pops the current top 2 entries correctly.
REQ-039 SHALL cover, with SLIFO_POP_ABORT_EN: abort after 2 pops of an 8-entry burst -> 2 entries delivered, then done with short_burst=1 and pop_count=2.
